// File: rtl/controle_pkg.sv
// Shared constants, state encoding and instruction field layout for the
// multi-cycle control unit.
package controle_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_NOP   = 6'h3F;

    localparam logic [3:0] ALUOP_ADDSUB_R = 4'b0010;
    localparam logic [3:0] ALUOP_SUB      = 4'b0001;
    localparam logic [3:0] ALUOP_NONE     = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_RETIRE    = 3'd4
    } estado_t;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 20;
    localparam int RT_HI    = 19;
    localparam int RT_LO    = 14;
    localparam int RD_HI    = 13;
    localparam int RD_LO    = 8;
    localparam int FUNCT_HI = 3;
    localparam int FUNCT_LO = 0;

endpackage

// File: rtl/decodificador_instr.sv
// Combinational opcode/funct decoder: produces the ALU control codes and the
// instruction class flags used by the control FSM.
module decodificador_instr
    import controle_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [3:0] instr_funct,
    output logic [3:0] alu_op,
    output logic [3:0] funct,
    output logic       is_rtype,
    output logic       is_beq,
    output logic       is_nop,
    output logic       is_illegal
);

    always_comb begin
        alu_op     = ALUOP_NONE;
        funct      = 4'b0000;
        is_rtype   = 1'b0;
        is_beq     = 1'b0;
        is_nop     = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                alu_op   = ALUOP_ADDSUB_R;
                funct    = instr_funct;
                is_rtype = 1'b1;
            end
            OP_BEQ: begin
                alu_op = ALUOP_SUB;
                is_beq = 1'b1;
            end
            OP_NOP: begin
                is_nop = 1'b1;
            end
            default: begin
                is_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: accepts one instruction word at a time, sequences
// the datapath through decode/execute/writeback and reports retirement.
module unidade_controle
    import controle_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    input  logic             ZERO,
    input  logic [31:0]      alu_result,
    output logic             enable,
    output logic             reg_write,
    output logic [3:0]       AluOP,
    output logic [3:0]       funct,
    output logic [5:0]       rs,
    output logic [5:0]       rt,
    output logic [5:0]       rd,
    output logic             done,
    output logic [31:0]      result_q,
    output logic             branch_taken,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    estado_t    state;
    estado_t    state_next;
    logic [5:0] ir_op;
    logic [5:0] ir_rs;
    logic [5:0] ir_rt;
    logic [5:0] ir_rd;
    logic [3:0] ir_funct;
    logic       accept;
    logic       is_rtype;
    logic       is_beq;
    logic       is_nop;
    logic       is_illegal;
    logic       unused_instr_bits;

    assign accept            = instr_valid && instr_ready;
    assign unused_instr_bits = ^instr[7:4];

    // Opcode resets to NOP so the ALU-code outputs come out of reset as zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ir_op    <= OP_NOP;
            ir_rs    <= '0;
            ir_rt    <= '0;
            ir_rd    <= '0;
            ir_funct <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                ir_op    <= instr[OPC_HI:OPC_LO];
                ir_rs    <= instr[RS_HI:RS_LO];
                ir_rt    <= instr[RT_HI:RT_LO];
                ir_rd    <= instr[RD_HI:RD_LO];
                ir_funct <= instr[FUNCT_HI:FUNCT_LO];
            end
        end
    end

    decodificador_instr u_dec (
        .opcode      (ir_op),
        .instr_funct (ir_funct),
        .alu_op      (AluOP),
        .funct       (funct),
        .is_rtype    (is_rtype),
        .is_beq      (is_beq),
        .is_nop      (is_nop),
        .is_illegal  (is_illegal)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:      if (accept) state_next = ST_DECODE;
            ST_DECODE:    state_next = (is_nop || is_illegal) ? ST_RETIRE : ST_EXECUTE;
            ST_EXECUTE:   state_next = is_beq ? ST_RETIRE : ST_WRITEBACK;
            ST_WRITEBACK: state_next = ST_RETIRE;
            ST_RETIRE:    state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    assign rs           = ir_rs;
    assign rt           = ir_rt;
    assign rd           = ir_rd;
    assign instr_ready  = (state == ST_IDLE);
    assign enable       = (state == ST_EXECUTE) || (state == ST_WRITEBACK);
    assign reg_write    = (state == ST_WRITEBACK) && (ir_rd != 6'd0);
    assign done         = (state == ST_RETIRE);
    assign branch_taken = done && is_beq && ZERO;
    assign illegal      = done && is_illegal;

    // Captured on the edge entering RETIRE so both are valid alongside done;
    // alu_result is already stable there since its operands are fixed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            retired  <= '0;
        end else if (state_next == ST_RETIRE) begin
            retired <= retired + CNT_W'(1);
            if (is_rtype || is_beq) begin
                result_q <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench for unidade_controle: stimulus pushes expected retirements,
// a negedge monitor pops and compares them whenever done is seen.
module tb_unidade_controle;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        ZERO;
    logic [31:0] alu_result;
    logic        enable;
    logic        reg_write;
    logic [3:0]  AluOP;
    logic [3:0]  funct;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [5:0]  rd;
    logic        done;
    logic [31:0] result_q;
    logic        branch_taken;
    logic        illegal;
    logic [15:0] retired;

    logic        w_valid;
    logic [31:0] w_instr;
    logic        w_ready;
    logic        w_zero;
    logic [31:0] w_alu;
    logic        w_enable;
    logic        w_reg_write;
    logic [3:0]  w_aluop;
    logic [3:0]  w_funct;
    logic [5:0]  w_rs;
    logic [5:0]  w_rt;
    logic [5:0]  w_rd;
    logic        w_done;
    logic [31:0] w_result;
    logic        w_bt;
    logic        w_ill;
    logic [3:0]  w_retired;

    unidade_controle #(.CNT_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .ZERO         (ZERO),
        .alu_result   (alu_result),
        .enable       (enable),
        .reg_write    (reg_write),
        .AluOP        (AluOP),
        .funct        (funct),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .done         (done),
        .result_q     (result_q),
        .branch_taken (branch_taken),
        .illegal      (illegal),
        .retired      (retired)
    );

    unidade_controle #(.CNT_W(4)) dut_w4 (
        .clock        (clock),
        .reset        (reset),
        .instr_valid  (w_valid),
        .instr        (w_instr),
        .instr_ready  (w_ready),
        .ZERO         (w_zero),
        .alu_result   (w_alu),
        .enable       (w_enable),
        .reg_write    (w_reg_write),
        .AluOP        (w_aluop),
        .funct        (w_funct),
        .rs           (w_rs),
        .rt           (w_rt),
        .rd           (w_rd),
        .done         (w_done),
        .result_q     (w_result),
        .branch_taken (w_bt),
        .illegal      (w_ill),
        .retired      (w_retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic        bt;
        logic        ill;
        logic [31:0] res;
        logic [15:0] ret;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_count = 0;
    int          acc_cyc[$];
    logic [31:0] m_res = 32'h0;
    logic [15:0] m_ret = 16'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(posedge clock) begin
        cyc++;
        if (!reset && instr_valid && instr_ready) begin
            acc_count++;
            acc_cyc.push_back(cyc);
        end
    end

    always @(negedge clock) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending instr (cycle %0d)",
                         cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("branch_taken", {31'b0, branch_taken}, {31'b0, mon_e.bt});
                chk("illegal", {31'b0, illegal}, {31'b0, mon_e.ill});
                chk("result_q", result_q, mon_e.res);
                chk("retired", {16'b0, retired}, {16'b0, mon_e.ret});
            end
        end
    end

    // Drive one instruction once the unit is ready; returns just after the accept edge.
    task automatic send(input logic [31:0] w, input logic [31:0] res, input logic z,
                        input bit track);
        int   n = 0;
        exp_t e;
        logic [5:0] op;
        @(negedge clock);
        while (!instr_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got instr_ready=0 expected 1 within 40 cycles");
        end
        instr       = w;
        instr_valid = 1'b1;
        alu_result  = res;
        ZERO        = z;
        if (track) begin
            op    = w[31:26];
            e.cyc = cyc + ((op == 6'h00) ? 4 : (op == 6'h04) ? 3 : 2);
            e.bt  = (op == 6'h04) && z;
            e.ill = !(op == 6'h00 || op == 6'h04 || op == 6'h3F);
            if (op == 6'h00 || op == 6'h04) m_res = res;
            m_ret = m_ret + 16'd1;
            e.res = m_res;
            e.ret = m_ret;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1);
    end

    initial begin
        int first;
        int n;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'h0;
        ZERO        = 1'b0;
        alu_result  = 32'h0;
        w_valid     = 1'b0;
        w_instr     = 32'h0;
        w_zero      = 1'b0;
        w_alu       = 32'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", {31'b0, instr_ready}, 32'd1);
        chk("rst_enable", {31'b0, enable}, 32'd0);
        chk("rst_reg_write", {31'b0, reg_write}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result_q", result_q, 32'd0);
        chk("rst_retired", {16'b0, retired}, 32'd0);
        chk("rst_aluop", {28'b0, AluOP}, 32'd0);
        chk("rst_rd", {26'b0, rd}, 32'd0);

        // Reset asserted during WRITEBACK abandons the instruction.
        send({6'h00, 6'd1, 6'd2, 6'd5, 4'h0, 4'h2}, 32'h55, 1'b0, 1'b0);
        instr_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("wb_reg_write_before_rst", {31'b0, reg_write}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_reg_write", {31'b0, reg_write}, 32'd0);
        chk("rst_async_enable", {31'b0, enable}, 32'd0);
        chk("rst_async_ready", {31'b0, instr_ready}, 32'd1);
        chk("rst_async_retired", {16'b0, retired}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // R-type: rs=1 rt=2 rd=3 funct=2.
        send({6'h00, 6'd1, 6'd2, 6'd3, 4'h0, 4'h2}, 32'h1234_5678, 1'b0, 1'b1);
        instr_valid = 1'b0;
        @(negedge clock);
        chk("rt_dec_ready", {31'b0, instr_ready}, 32'd0);
        chk("rt_dec_enable", {31'b0, enable}, 32'd0);
        chk("rt_rs", {26'b0, rs}, 32'd1);
        chk("rt_rt", {26'b0, rt}, 32'd2);
        chk("rt_rd", {26'b0, rd}, 32'd3);
        chk("rt_aluop", {28'b0, AluOP}, 32'd2);
        chk("rt_funct", {28'b0, funct}, 32'd2);
        @(negedge clock);
        chk("rt_ex_enable", {31'b0, enable}, 32'd1);
        chk("rt_ex_reg_write", {31'b0, reg_write}, 32'd0);
        @(negedge clock);
        chk("rt_wb_enable", {31'b0, enable}, 32'd1);
        chk("rt_wb_reg_write", {31'b0, reg_write}, 32'd1);
        @(negedge clock);
        chk("rt_ret_reg_write", {31'b0, reg_write}, 32'd0);
        chk("rt_ret_enable", {31'b0, enable}, 32'd0);
        @(negedge clock);
        chk("rt_idle_done", {31'b0, done}, 32'd0);
        chk("rt_idle_rd_hold", {26'b0, rd}, 32'd3);

        // BEQ with ZERO=1 then ZERO=0.
        send({6'h04, 6'd4, 6'd4, 6'd0, 8'h00}, 32'h0, 1'b1, 1'b1);
        instr_valid = 1'b0;
        @(negedge clock);
        chk("beq_aluop", {28'b0, AluOP}, 32'd1);
        chk("beq_funct", {28'b0, funct}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("beq_no_write", {31'b0, reg_write}, 32'd0);
        end
        send({6'h04, 6'd4, 6'd5, 6'd0, 8'h00}, 32'h7, 1'b0, 1'b1);
        instr_valid = 1'b0;
        repeat (3) @(negedge clock);

        // R-type with rd=0 retires without a write strobe.
        send({6'h00, 6'd1, 6'd2, 6'd0, 4'h0, 4'h6}, 32'hABCD, 1'b0, 1'b1);
        instr_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("rd0_wb_enable", {31'b0, enable}, 32'd1);
        chk("rd0_wb_reg_write", {31'b0, reg_write}, 32'd0);
        @(negedge clock);

        // Illegal opcode keeps result_q and never enables the ALU.
        send({6'h15, 26'h0}, 32'hDEAD_BEEF, 1'b0, 1'b1);
        instr_valid = 1'b0;
        @(negedge clock);
        chk("ill_dec_enable", {31'b0, enable}, 32'd0);
        chk("ill_aluop", {28'b0, AluOP}, 32'd0);
        @(negedge clock);
        chk("ill_ret_enable", {31'b0, enable}, 32'd0);

        send({6'h3F, 26'h0}, 32'h99, 1'b0, 1'b1);
        instr_valid = 1'b0;
        repeat (2) @(negedge clock);

        // Back-to-back R-types with instr_valid held high.
        n     = acc_count;
        first = acc_cyc.size();
        send({6'h00, 6'd7, 6'd8, 6'd9, 4'h0, 4'h1}, 32'h111, 1'b0, 1'b1);
        send({6'h00, 6'd10, 6'd11, 6'd12, 4'h0, 4'h3}, 32'h222, 1'b0, 1'b1);
        @(negedge clock);
        chk("b2b_busy_ready", {31'b0, instr_ready}, 32'd0);
        send({6'h00, 6'd13, 6'd14, 6'd15, 4'h0, 4'h4}, 32'h333, 1'b0, 1'b1);
        instr_valid = 1'b0;
        repeat (8) @(negedge clock);
        chk("b2b_accepts", acc_count - n, 32'd3);
        if (acc_cyc.size() >= first + 3) begin
            chk("b2b_spacing_1", acc_cyc[first+1] - acc_cyc[first], 32'd5);
            chk("b2b_spacing_2", acc_cyc[first+2] - acc_cyc[first+1], 32'd5);
        end

        // Counter wrap on the 4-bit instance: 17 NOPs.
        for (int i = 1; i <= 17; i++) begin
            @(negedge clock);
            n = 0;
            while (!w_ready && n < 10) begin
                @(negedge clock);
                n++;
            end
            w_instr = {6'h3F, 26'h0};
            w_valid = 1'b1;
            @(posedge clock);
            #1;
            w_valid = 1'b0;
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!w_done && n < 10);
            chk("wrap_latency", n, 32'd2);
            chk("wrap_retired", {28'b0, w_retired}, i % 16);
        end

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle control unit that drives the datapath integration block (ALU control + ALU + register file) from a stream of 32-bit instruction words. It accepts one instruction at a time over a valid/ready handshake and decodes it into the datapath's `AluOP`, `funct`, `rs`, `rt` and `rd` fields. It sequences `enable` and `reg_write` over fixed states, samples `ZERO` and the datapath result, and reports completion, branch outcome and illegal opcodes upstream.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clock`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `instr_valid`  in  1  upstream has an instruction on `instr`.
- `instr`  in  32  instruction word: [31:26] opcode, [25:20] rs, [19:14] rt, [13:8] rd, [7:4] ignored, [3:0] funct.
- `instr_ready`  out  1  unit can accept an instruction.
- `ZERO`  in  1  datapath ALU zero flag.
- `alu_result`  in  32  datapath ALU result.
- `enable`  out  1  ALU enable to datapath.
- `reg_write`  out  1  register-file write strobe to datapath.
- `AluOP`  out  4  to ALU control.
- `funct`  out  4  to ALU control.
- `rs`, `rt`, `rd`  out  6 each  register addresses to datapath.
- `done`  out  1  one-cycle pulse: instruction retired.
- `result_q`  out  32  `alu_result` captured at retirement.
- `branch_taken`  out  1  valid with `done`: BEQ and `ZERO`=1.
- `illegal`  out  1  valid with `done`: opcode not recognised.
- `retired`  out  CNT_W  count of retired instructions, legal and illegal.

## Operation
- Opcodes:
  - `OP_RTYPE`=6'h00: AluOP=4'b0010, funct from instr; writes rd.
  - `OP_BEQ`=6'h04: AluOP=4'b0001, funct=4'b0000; no write; result is the branch flag.
  - `OP_NOP`=6'h3F: AluOP=4'b0000; no enable, no write.
  - All other opcodes are illegal.
- States: IDLE, DECODE, EXECUTE, WRITEBACK, RETIRE.
  - IDLE: `instr_ready`=1. `instr_valid`&`instr_ready` latches `instr` into the instruction register and moves to DECODE.
  - DECODE: `rs`/`rt`/`rd`/`AluOP`/`funct` are driven from the latched word. Legal non-NOP → EXECUTE; NOP or illegal → RETIRE.
  - EXECUTE: `enable`=1. BEQ → RETIRE; R-type → WRITEBACK.
  - WRITEBACK: `enable`=1 and `reg_write`=1 for exactly one cycle. When `rd`==0, `reg_write` stays 0 because register 0 is never written.
  - RETIRE: `done`=1. `result_q`←`alu_result` for R-type and BEQ only; otherwise it holds. `branch_taken`←BEQ&`ZERO` sampled this cycle. `illegal`←opcode-illegal. `retired`+1, wrapping from all-ones to 0. Next state is IDLE.
- Register-address and ALU-code outputs hold their last value in IDLE and RETIRE.
- `enable` and `reg_write` are 0 outside the states listed above.
- `instr` is ignored outside IDLE. `instr_valid` held high during busy cycles is not consumed until the next IDLE.

## Timing
- Reset values: state=IDLE; `instr_ready`=1; all other outputs 0, including `result_q` and `retired`.
- Reset asserted mid-instruction drops `enable`/`reg_write` immediately, without waiting for a clock edge, and abandons the instruction. `retired` is not incremented.
- Latency from the accept edge to the `done` cycle:
  - R-type: 4 cycles (DECODE, EXECUTE, WRITEBACK, RETIRE).
  - BEQ: 3 cycles.
  - NOP and illegal: 2 cycles.
- Maximum throughput is one instruction per 5 cycles (R-type). `instr_ready` is low from DECODE through RETIRE.
- The register file writes on the clock edge that ends WRITEBACK. `alu_result` must stay stable from EXECUTE through RETIRE, because its operands do not change until the next DECODE.

## Structure
- Shared package `controle_pkg`:
  - opcode constants `OP_RTYPE`, `OP_BEQ`, `OP_NOP`;
  - AluOP codes `ALUOP_ADDSUB_R`=4'b0010, `ALUOP_SUB`=4'b0001, `ALUOP_NONE`=4'b0000;
  - state enum `estado_t`;
  - instruction field bit positions.
- One combinational sub-module, `decodificador_instr`. It maps opcode/funct to AluOP, funct, is_rtype, is_beq, is_nop and is_illegal. The FSM, instruction register, capture registers and counter live in `unidade_controle`.

## Test plan
- **R-type:** after reset, send opcode 0, rs=1, rt=2, rd=3, funct=4'h2. Expect `enable` high in 2 cycles, `reg_write` high only in the WRITEBACK cycle, and rd=3. `done` comes 4 cycles after accept with `result_q`=`alu_result`, and `retired`=1.
- **BEQ:** send opcode 6'h04 with `ZERO` driven 1, then 0. Expect no `reg_write`, `done` 3 cycles after accept, and `branch_taken`=1 then 0.
- **rd=0 and illegal opcode:** an R-type with rd=0 never asserts `reg_write` but still retires. Opcode 6'h15 gives `done` 2 cycles after accept with `illegal`=1, no `enable`, and `result_q` unchanged.
- **Back-to-back:** hold `instr_valid` high with 3 instructions. Expect exactly 3 accepts, `instr_ready` low in busy states, and accepts 5 cycles apart for R-types.
- **Reset during WRITEBACK:** expect `reg_write` to fall asynchronously, state=IDLE, `retired` unchanged and `instr_ready`=1.
- **Counter wrap:** with `CNT_W`=4, retire 17 NOPs. Expect `retired` to step 15→0→1.
